// File: rtl/present80_pkg.sv
// present80_pkg: shared PRESENT-80 constants, S-box and FSM encodings
package present80_pkg;

    localparam int PRESENT80_ROUNDS = 31;
    localparam logic [63:0] SBOX = 64'hC56B90AD3EF84712;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Input 0 selects the leftmost table digit, so the bit offset is 4*(15-x).
    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{~x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present80_key_update.sv
// present80_key_update: PRESENT-80 key schedule step for round counter rc
module present80_key_update
    import present80_pkg::*;
(
    input  logic [79:0] key,
    input  logic [4:0]  rc,
    output logic [79:0] key_next
);

    logic [79:0] kr;

    assign kr = {key[18:0], key[79:19]};
    assign key_next = {sbox(kr[79:76]), kr[75:20], kr[19:15] ^ rc, kr[14:0]};

endmodule

// File: rtl/present80_round.sv
// present80_round: one PRESENT round (key addition, sBoxLayer, pLayer)
module present80_round
    import present80_pkg::*;
(
    input  logic [63:0] state,
    input  logic [63:0] round_key,
    output logic [63:0] round_out
);

    logic [63:0] x;
    logic [63:0] s;

    assign x = state ^ round_key;

    for (genvar j = 0; j < 16; j++) begin : g_s
        assign s[4*j +: 4] = sbox(x[4*j +: 4]);
    end

    // Bit i moves to 16*i mod 63; bit 63 stays in place.
    for (genvar i = 0; i < 64; i++) begin : g_p
        assign round_out[(i == 63) ? 63 : (i * 16) % 63] = s[i];
    end

endmodule

// File: rtl/present80_iter_ctrl.sv
// present80_iter_ctrl: iterative PRESENT-80 encryptor, one round per clock, valid/ready on both sides
module present80_iter_ctrl
    import present80_pkg::*;
#(
    parameter int ROUNDS = PRESENT80_ROUNDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_text,
    input  logic [79:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_text,
    output logic        busy
);

    fsm_t        fsm_q, fsm_d;
    logic [63:0] state_q, state_d, result_q, result_d, round_out;
    logic [79:0] key_q, key_d, kr;
    logic [4:0]  rc_q, rc_d;

    present80_round u_round (
        .state     (state_q),
        .round_key (key_q[79:16]),
        .round_out (round_out)
    );

    present80_key_update u_key (
        .key      (key_q),
        .rc       (rc_q),
        .key_next (kr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            key_q    <= '0;
            rc_q     <= '0;
            result_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            key_q    <= key_d;
            rc_q     <= rc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        key_d    = key_q;
        rc_d     = rc_q;
        result_d = result_q;
        case (fsm_q)
            IDLE: if (in_valid) begin
                state_d = in_text;
                key_d   = in_key;
                rc_d    = 5'd1;
                fsm_d   = RUN;
            end
            RUN: if (rc_q == 5'(ROUNDS)) begin
                // Last round: apply whitening with the next key; rc_q holds so it never wraps.
                result_d = round_out ^ kr[79:16];
                fsm_d    = DONE;
            end else begin
                state_d = round_out;
                key_d   = kr;
                rc_d    = rc_q + 5'd1;
            end
            DONE: fsm_d = out_ready ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q == RUN);
    assign out_valid = (fsm_q == DONE);
    assign out_text  = result_q;

endmodule

// File: tb/tb_present80_iter_ctrl.sv
// tb_present80_iter_ctrl: directed vector bench for present80_iter_ctrl
module tb_present80_iter_ctrl;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [63:0] in_text = '0;
    logic [79:0] in_key = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [63:0] out_text;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] text;
        logic [79:0] key;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[4];

    present80_iter_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one block at a negedge; returns with in_valid low, half a cycle after acceptance.
    task automatic accept(input logic [63:0] t, input logic [79:0] k);
        @(negedge clk);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_text  = t;
        in_key   = k;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        in_text  = '0;
        in_key   = '0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    initial begin
        int n;
        int last_acc;
        logic [63:0] held;
        vecs[0] = '{64'h0, 80'h0, 64'h5579C1387B228445};
        vecs[1] = '{64'h0, {80{1'b1}}, 64'hE72C46C0F5945049};
        vecs[2] = '{{64{1'b1}}, 80'h0, 64'hA112FFC72F68417B};
        vecs[3] = '{{64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2};

        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_out_text", out_text, 64'd0);

        for (int i = 0; i < 4; i++) begin
            accept(vecs[i].text, vecs[i].key);
            check("busy_in_run", 64'(busy), 64'd1);
            wait_out(n);
            check("latency", 64'(n), 64'd31);
            check("cipher", out_text, vecs[i].exp);
            drain();
            check("in_ready_after_drain", 64'(in_ready), 64'd1);
            check("out_text_held", out_text, vecs[i].exp);
        end

        accept(vecs[3].text, vecs[3].key);
        wait_out(n);
        held = out_text;
        check("hold_cipher", held, vecs[3].exp);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_text", out_text, vecs[3].exp);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        drain();

        accept(vecs[0].text, vecs[0].key);
        repeat (4) @(negedge clk);
        in_text  = {64{1'b1}};
        in_key   = {80{1'b1}};
        in_valid = 1;
        check("ignore_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 0;
        wait_out(n);
        check("ignore_latency", 64'(n), 64'd26);
        check("ignore_cipher", out_text, vecs[0].exp);
        drain();

        accept(vecs[1].text, vecs[1].key);
        repeat (14) @(negedge clk);
        rst_n = 0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_text", out_text, 64'd0);
        @(negedge clk);
        rst_n = 1;
        accept(vecs[0].text, vecs[0].key);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        wait_out(n);
        check("post_rst_latency", 64'(n), 64'd31);
        check("post_rst_cipher", out_text, vecs[0].exp);
        drain();

        out_ready = 1;
        last_acc = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_text  = vecs[i].text;
            in_key   = vecs[i].key;
            in_valid = 1;
            n = 0;
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("b2b_in_ready_seen", 64'(in_ready), 64'd1);
            if (last_acc >= 0) check("b2b_spacing", 64'(cyc - last_acc), 64'd33);
            last_acc = cyc;
            @(negedge clk);
            wait_out(n);
            check("b2b_cipher", out_text, vecs[i].exp);
        end
        in_valid = 0;
        out_ready = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
